// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch and decode.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc,
    input  logic                     in_exc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_pcplus4,
    output logic                     out_exc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [64:0]   mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [64:0]   head;
    logic          empty;
    logic          full;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          wr;
    logic          rd;

    assign empty = (count == '0);
    assign full  = (count == FULL);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // No pop-through when full keeps out_ready off the in_ready path.
    assign in_ready  = ~full & ~flush;
    assign out_valid = (~empty & ~flush) | bypass;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;
    assign wr   = push & ~(bypass & out_ready);
    assign rd   = pop & ~empty;

    // Head selection: stored entry, bypassed input, or zeros when empty.
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rptr];
        end else if (bypass) begin
            head = {in_exc, in_pc, in_instr};
        end
    end

    assign {out_exc, out_pc, out_instr} = head;
    assign out_pcplus4 = out_pc + 32'd4;

    // Entry storage; contents survive flush and reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= {in_exc, in_pc, in_instr};
        end
    end

    // Pointers and occupancy; flush behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + AW'(1);
            end
            if (rd) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({wr, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus scoreboard streaming
// for fetch_queue at DEPTH=4.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit B = 1'b1;
`else
    localparam bit B = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_exc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic        out_exc;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;
    int seq   = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_exc      (in_exc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pcplus4 (out_pcplus4),
        .out_exc     (out_exc),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] ii;
        logic [31:0] ip;
        logic        ie;
        logic        ordy;
        logic        x_ir;
        logic        x_ov;
        logic [31:0] x_ii;
        logic [31:0] x_ip;
        logic [31:0] x_p4;
        logic        x_ie;
        logic [2:0]  x_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
    } ent_t;

    vec_t v[$];
    ent_t q[$];

    function automatic void add(string nm, int rst, int fl, int iv,
                                logic [31:0] ii, logic [31:0] ip,
                                int ie, int ordy, int x_ir, int x_ov,
                                logic [31:0] x_ii, logic [31:0] x_ip,
                                logic [31:0] x_p4, int x_ie, int x_cnt);
        vec_t r;
        r.nm    = nm;
        r.rst   = (rst != 0);
        r.fl    = (fl != 0);
        r.iv    = (iv != 0);
        r.ii    = ii;
        r.ip    = ip;
        r.ie    = (ie != 0);
        r.ordy  = (ordy != 0);
        r.x_ir  = (x_ir != 0);
        r.x_ov  = (x_ov != 0);
        r.x_ii  = x_ii;
        r.x_ip  = x_ip;
        r.x_p4  = x_p4;
        r.x_ie  = (x_ie != 0);
        r.x_cnt = 3'(x_cnt);
        v.push_back(r);
    endfunction

    task automatic sb_cycle(input bit iv, input bit ordy, input bit fl,
                            input int want_cnt);
        ent_t e;
        ent_t h;
        int   sz;
        e.instr = $urandom;
        e.pc    = 32'(seq * 4);
        e.exc   = ($urandom_range(0, 7) == 0);
        seq++;
        flush     = fl;
        in_valid  = iv;
        in_instr  = e.instr;
        in_pc     = e.pc;
        in_exc    = e.exc;
        out_ready = ordy;
        @(negedge clk);
        sz = q.size();
        tests++;
        if (int'(count) != sz) begin
            fails++;
            $display("FAIL sb_count: got %0d exp %0d", count, sz);
        end
        if (want_cnt >= 0) begin
            tests++;
            if (int'(count) != want_cnt) begin
                fails++;
                $display("FAIL stream_count: got %0d exp %0d",
                         count, want_cnt);
            end
        end
        tests++;
        if (in_ready !== ((sz != 4) && !fl)) begin
            fails++;
            $display("FAIL sb_in_ready: got %0b exp %0b",
                     in_ready, (sz != 4) && !fl);
        end
        if (fl) begin
            q.delete();
        end else begin
            if (in_valid && in_ready) begin
                q.push_back(e);
            end
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_pop: got pc=%h exp no entry", out_pc);
                end else begin
                    h = q.pop_front();
                    if (out_instr !== h.instr || out_pc !== h.pc ||
                        out_exc !== h.exc ||
                        out_pcplus4 !== h.pc + 32'd4) begin
                        fails++;
                        $display("FAIL sb_head: got %h/%h/%0b exp %h/%h/%0b",
                                 out_instr, out_pc, out_exc,
                                 h.instr, h.pc, h.exc);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        in_exc    = 1'b0;
        out_ready = 1'b0;

        add("reset_state", 0,0,0, 0,0,0,0, 1,0, 0,0,4,0,0);
        add("push_first", 0,0,1, 32'h24080001,32'hBFC00000,0,1,
            1,B, B ? 32'h24080001 : 32'h0, B ? 32'hBFC00000 : 32'h0,
            B ? 32'hBFC00004 : 32'h4, 0,0);
        add("first_head", 0,0,0, 0,0,0,1,
            1,!B, !B ? 32'h24080001 : 32'h0, !B ? 32'hBFC00000 : 32'h0,
            !B ? 32'hBFC00004 : 32'h4, 0, B ? 0 : 1);
        add("first_done", 0,0,0, 0,0,0,0, 1,0, 0,0,4,0,0);
        add("fill0", 0,0,1, 32'hA0000000,0,0,0,
            1,B, B ? 32'hA0000000 : 32'h0, 0,4,0,0);
        for (int k = 1; k < 4; k++) begin
            add("fill", 0,0,1, 32'hA0000000 + k, 4 * k,0,0,
                1,1, 32'hA0000000,0,4,0,k);
        end
        add("full", 0,0,1, 32'hA0000004,32'h10,0,0,
            0,1, 32'hA0000000,0,4,0,4);
        for (int k = 0; k < 4; k++) begin
            add("drain", 0,0,0, 0,0,0,1,
                (k == 0) ? 0 : 1, 1, 32'hA0000000 + k, 4 * k,
                4 * k + 4, 0, 4 - k);
        end
        add("drained", 0,0,0, 0,0,0,0, 1,0, 0,0,4,0,0);
        add("refill0", 0,0,1, 32'hB0000000,32'h20,0,0,
            1,B, B ? 32'hB0000000 : 32'h0, B ? 32'h20 : 32'h0,
            B ? 32'h24 : 32'h4, 0,0);
        for (int k = 1; k < 4; k++) begin
            add("refill", 0,0,1, 32'hB0000000 + k, 32'h20 + 4 * k,0,0,
                1,1, 32'hB0000000,32'h20,32'h24,0,k);
        end
        add("full_pop", 0,0,1, 32'hB0000004,32'h30,0,1,
            0,1, 32'hB0000000,32'h20,32'h24,0,4);
        add("ready_after", 0,0,0, 0,0,0,0,
            1,1, 32'hB0000001,32'h24,32'h28,0,3);
        add("flush_cycle", 0,1,1, 32'hC0000000,32'h40,0,1,
            0,0, 32'hB0000001,32'h24,32'h28,0,3);
        add("post_flush", 0,0,1, 32'h11111111,32'h80000180,0,0,
            1,B, B ? 32'h11111111 : 32'h0, B ? 32'h80000180 : 32'h0,
            B ? 32'h80000184 : 32'h4, 0,0);
        add("flush_head", 0,0,0, 0,0,0,0,
            1,1, 32'h11111111,32'h80000180,32'h80000184,0,1);
        add("pushpop_c1", 0,0,1, 32'h22222222,32'hFFFFFFFC,1,1,
            1,1, 32'h11111111,32'h80000180,32'h80000184,0,1);
        add("pc_wrap_exc", 0,0,0, 0,0,0,0,
            1,1, 32'h22222222,32'hFFFFFFFC,32'h0,1,1);
        add("pop_exc", 0,0,0, 0,0,0,1,
            1,1, 32'h22222222,32'hFFFFFFFC,32'h0,1,1);
        add("empty_again", 0,0,0, 0,0,0,0, 1,0, 0,0,4,0,0);
        add("push_pre_rst", 0,0,1, 32'h33333333,32'h100,0,0,
            1,B, B ? 32'h33333333 : 32'h0, B ? 32'h100 : 32'h0,
            B ? 32'h104 : 32'h4, 0,0);
        add("rst_mid", 1,0,0, 0,0,0,0,
            1,1, 32'h33333333,32'h100,32'h104,0,1);
        add("after_rst", 0,0,0, 0,0,0,0, 1,0, 0,0,4,0,0);
        add("rst_flush", 1,1,1, 32'h44444444,32'h200,0,0,
            0,0, 0,0,4,0,0);
        add("after_both", 0,0,0, 0,0,0,0, 1,0, 0,0,4,0,0);

        repeat (2) @(posedge clk);
        #1;

        foreach (v[i]) begin
            reset     = v[i].rst;
            flush     = v[i].fl;
            in_valid  = v[i].iv;
            in_instr  = v[i].ii;
            in_pc     = v[i].ip;
            in_exc    = v[i].ie;
            out_ready = v[i].ordy;
            @(negedge clk);
            tests++;
            if ({in_ready, out_valid, out_instr, out_pc, out_pcplus4,
                 out_exc, count} !==
                {v[i].x_ir, v[i].x_ov, v[i].x_ii, v[i].x_ip, v[i].x_p4,
                 v[i].x_ie, v[i].x_cnt}) begin
                fails++;
                $display("FAIL %s: got ir=%0b ov=%0b i=%h pc=%h p4=%h e=%0b c=%0d exp ir=%0b ov=%0b i=%h pc=%h p4=%h e=%0b c=%0d",
                         v[i].nm, in_ready, out_valid, out_instr, out_pc,
                         out_pcplus4, out_exc, count, v[i].x_ir, v[i].x_ov,
                         v[i].x_ii, v[i].x_ip, v[i].x_p4, v[i].x_ie,
                         v[i].x_cnt);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        // Wrap-around stream at occupancy 2.
        sb_cycle(1'b1, 1'b0, 1'b0, -1);
        sb_cycle(1'b1, 1'b0, 1'b0, -1);
        for (int k = 0; k < 10; k++) begin
            sb_cycle(1'b1, 1'b1, 1'b0, 2);
        end
        for (int k = 0; k < 6 && q.size() != 0; k++) begin
            sb_cycle(1'b0, 1'b1, 1'b0, -1);
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL stream_drain: got %0d left exp 0", q.size());
        end

        // Random traffic with occasional flushes.
        for (int k = 0; k < 300; k++) begin
            sb_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 24) == 0, -1);
        end
        for (int k = 0; k < 8 && q.size() != 0; k++) begin
            sb_cycle(1'b0, 1'b1, 1'b0, -1);
        end
        tests++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL random_drain: got %0d left ov=%0b exp 0 ov=0",
                     q.size(), out_valid);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
